wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Two-master to one-slave Wishbone arbiter. Bus ownership is
//            granted one cycle after a request, ties are resolved round-robin
//            and the owner keeps the bus while its cyc stays high (bus lock).
//            Dropping cyc returns the arbiter to IDLE, which leaves one dead
//            cycle before the next grant.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional : WB_ARBITER_TIMEOUT_EN - when defined, a stalled slave (strobe
//            held without ack/err/rty for TIMEOUT_CYCLES cycles) is abandoned:
//            the owner gets a one-cycle error, cyc/stb drop and the arbiter
//            returns to IDLE. Without it a stalled slave holds the grant.
// ----------------------------------------------------------------------------
// Ports    : clk_i, rst_i (async, active-high)
//            m_cyc_i/m_stb_i/m_we_i [1:0]  per-master control, bit n = master n
//            m_adr_i/m_dat_i [63:0]        master 0 in [31:0], master 1 in [63:32]
//            m_sel_i [7:0]                 master 0 in [3:0], master 1 in [7:4]
//            m_dat_o [31:0]                slave read data, to both masters
//            m_ack_o/m_err_o/m_rty_o [1:0] terminations, owner bit only
//            s_cyc_o/s_stb_o/s_we_o        slave-side control
//            s_adr_o/s_dat_o [31:0], s_sel_o [3:0]
//            s_dat_i [31:0], s_ack_i/s_err_i/s_rty_i
//            grant_o [1:0]                 one-hot owner, 00 when idle
// ============================================================================
module wb_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  m_cyc_i,
  input  logic [1:0]  m_stb_i,
  input  logic [1:0]  m_we_i,
  input  logic [63:0] m_adr_i,
  input  logic [7:0]  m_sel_i,
  input  logic [63:0] m_dat_i,
  output logic [31:0] m_dat_o,
  output logic [1:0]  m_ack_o,
  output logic [1:0]  m_err_o,
  output logic [1:0]  m_rty_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last;     // index of the master granted most recently
  logic   w_timeout;  // owner abandoned this cycle because the slave stalled

  generate
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
      $error("wb_arbiter: TIMEOUT_CYCLES must be in 1..65535");
    end
  endgenerate

`ifdef WB_ARBITER_TIMEOUT_EN
  localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_to_cnt;
  logic        w_own_stb;
  logic        w_term;
  logic        w_stall;

  // Stall is judged on the owner's own strobe, not on s_stb_o, because
  // s_stb_o is itself forced low in the timeout cycle.
  always_comb begin
    w_own_stb = 1'b0;
    case (r_state)
      OWN0:    w_own_stb = m_cyc_i[0] & m_stb_i[0];
      OWN1:    w_own_stb = m_cyc_i[1] & m_stb_i[1];
      default: w_own_stb = 1'b0;
    endcase
  end

  assign w_term    = s_ack_i | s_err_i | s_rty_i;
  assign w_stall   = (r_state != IDLE) && w_own_stb && !w_term;
  // Fires during the stalled cycle that brings the count to TIMEOUT_CYCLES.
  assign w_timeout = w_stall && (r_to_cnt == c_TO_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_to_cnt <= 16'd0;
    end else if ((r_state == IDLE) || w_term || w_timeout) begin
      r_to_cnt <= 16'd0;
    end else if (w_stall) begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State and round-robin history
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == OWN0) begin
        r_last <= 1'b0;
      end else if (r_state == IDLE && w_next == OWN1) begin
        r_last <= 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        case (m_cyc_i)
          2'b01:   w_next = OWN0;
          2'b10:   w_next = OWN1;
          2'b11:   w_next = r_last ? OWN0 : OWN1;
          default: w_next = IDLE;
        endcase
      end
      OWN0: begin
        if (!m_cyc_i[0] || w_timeout) begin
          w_next = IDLE;
        end
      end
      OWN1: begin
        if (!m_cyc_i[1] || w_timeout) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Bus multiplexing; everything is zero while idle
  always_comb begin
    grant_o = 2'b00;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = 32'd0;
    s_dat_o = 32'd0;
    s_sel_o = 4'd0;
    m_ack_o = 2'b00;
    m_err_o = 2'b00;
    m_rty_o = 2'b00;
    case (r_state)
      OWN0: begin
        grant_o    = 2'b01;
        s_cyc_o    = m_cyc_i[0] & ~w_timeout;
        s_stb_o    = m_stb_i[0] & ~w_timeout;
        s_we_o     = m_we_i[0];
        s_adr_o    = m_adr_i[31:0];
        s_dat_o    = m_dat_i[31:0];
        s_sel_o    = m_sel_i[3:0];
        m_ack_o[0] = s_ack_i;
        m_err_o[0] = s_err_i | w_timeout;
        m_rty_o[0] = s_rty_i;
      end
      OWN1: begin
        grant_o    = 2'b10;
        s_cyc_o    = m_cyc_i[1] & ~w_timeout;
        s_stb_o    = m_stb_i[1] & ~w_timeout;
        s_we_o     = m_we_i[1];
        s_adr_o    = m_adr_i[63:32];
        s_dat_o    = m_dat_i[63:32];
        s_sel_o    = m_sel_i[7:4];
        m_ack_o[1] = s_ack_i;
        m_err_o[1] = s_err_i | w_timeout;
        m_rty_o[1] = s_rty_i;
      end
      default: ;
    endcase
  end

  assign m_dat_o = s_dat_i;

endmodule
`default_nettype wire
